// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Brief    : Writeback stage of the 8-bit RISC-V pipeline. It holds the
//             MEM/WB register, drives the register-file write port, exports
//             a forwarding tap and counts retired instructions.
//  Revision : 1.0  initial release
// ============================================================================
module wb_stage #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic                  mem_to_reg,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]     mem_alu_result,
    input  logic [DATA_W-1:0]     mem_load_data,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  wb_ready,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_reg_data,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [CNT_W-1:0]      retired_count
);

    logic                  wb_valid_q,     wb_valid_d;
    logic                  wb_reg_write_q, wb_reg_write_d;
    logic [REG_ADDR_W-1:0] wb_rd_q,        wb_rd_d;
    logic [DATA_W-1:0]     wb_data_q,      wb_data_d;
    logic [CNT_W-1:0]      count_q,        count_d;

    // stall acts purely as a hold enable; the captured values never depend on it
    always_comb begin
        wb_valid_d     = wb_valid_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        count_d        = count_q;
        if (!stall) begin
            wb_valid_d     = mem_valid & ~flush;
            wb_reg_write_d = mem_valid & ~flush & mem_reg_write & (mem_rd != '0);
            wb_rd_d        = mem_rd;
            wb_data_d      = mem_to_reg ? mem_load_data : mem_alu_result;
            count_d        = count_q + {{(CNT_W-1){1'b0}}, wb_valid_q};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            count_q        <= '0;
        end else begin
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            count_q        <= count_d;
        end
    end

    assign wb_ready       = ~stall;
    assign reg_write      = wb_reg_write_q & ~stall;
    assign write_reg      = wb_rd_q;
    assign write_reg_data = wb_data_q;
    // forwarding stays live during a stall so the hazard unit can still bypass
    assign fwd_valid      = wb_reg_write_q;
    assign fwd_rd         = wb_rd_q;
    assign fwd_data       = wb_data_q;
    assign retired_count  = count_q;

endmodule
`default_nettype wire
